// File: rtl/channel_sched_pkg.sv
// channel_sched_pkg: shared encodings, config addresses and reset defaults for the channel scheduler.
package channel_sched_pkg;
    localparam logic ST_GOOD = 1'b0;
    localparam logic ST_BAD = 1'b1;
    typedef enum logic {STOPPED, RUNNING} ctrl_t;
    localparam logic [1:0] CFG_TH_GB = 2'd0;
    localparam logic [1:0] CFG_TH_BG = 2'd1;
    localparam logic [1:0] CFG_SNR_GOOD = 2'd2;
    localparam logic [1:0] CFG_SNR_BAD = 2'd3;
    localparam logic [7:0] DEFAULT_TH_GB = 8'd97;
    localparam logic [7:0] DEFAULT_TH_BG = 8'd75;
    localparam logic [7:0] DEFAULT_SNR_GOOD = 8'd21;
    localparam logic [7:0] DEFAULT_SNR_BAD = 8'd9;
    localparam logic [15:0] FALLBACK_SEED = 16'hACE1;
    function automatic logic [15:0] sat_inc(logic [15:0] v);
        return &v ? v : v + 16'd1;
    endfunction
endpackage

// File: rtl/channel_state_scheduler_if.sv
// channel_state_scheduler_if: control, config and status bus of the channel scheduler.
interface channel_state_scheduler_if;
    logic run;
    logic step;
    logic cfg_we;
    logic [1:0] cfg_addr;
    logic [7:0] cfg_wdata;
    logic clr_stats;
    logic update;
    logic state_bad;
    logic [7:0] snr_code;
    logic [6:0] rand_sample;
    logic [15:0] eval_count;
    logic [15:0] bad_count;
    modport master (
        output run, step, cfg_we, cfg_addr, cfg_wdata, clr_stats,
        input update, state_bad, snr_code, rand_sample, eval_count, bad_count
    );
    modport slave (
        input run, step, cfg_we, cfg_addr, cfg_wdata, clr_stats,
        output update, state_bad, snr_code, rand_sample, eval_count, bad_count
    );
endinterface

// File: rtl/channel_lfsr16.sv
// channel_lfsr16: 16-bit Fibonacci LFSR (taps 16,14,13,11) stepping only when advance is high.
module channel_lfsr16
    import channel_sched_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        advance,
    output logic [15:0] value
);
    // An all-zero seed would lock the register, so it falls back to the default seed.
    localparam logic [15:0] INIT = (SEED == 16'd0) ? FALLBACK_SEED : SEED;

    always_ff @(posedge clk) begin
        if (reset)
            value <= INIT;
        else if (advance)
            value <= {value[14:0], value[15] ^ value[13] ^ value[12] ^ value[10]};
    end
endmodule

// File: rtl/channel_state_scheduler.sv
// channel_state_scheduler: evaluation sequencer, config registers and Good/Bad state for the burst-error channel.
module channel_state_scheduler
    import channel_sched_pkg::*;
#(
    parameter int unsigned TICK_DIV = 5000,
    parameter logic [15:0] LFSR_SEED = 16'hACE1,
    parameter logic [7:0]  DEF_TH_GB = DEFAULT_TH_GB,
    parameter logic [7:0]  DEF_TH_BG = DEFAULT_TH_BG,
    parameter logic [7:0]  DEF_SNR_GOOD = DEFAULT_SNR_GOOD,
    parameter logic [7:0]  DEF_SNR_BAD = DEFAULT_SNR_BAD
) (
    input logic clk,
    input logic reset,
    channel_state_scheduler_if.slave bus
);
    localparam logic [15:0] TICK_LAST = 16'(TICK_DIV - 1);

    ctrl_t ctrl, ctrl_nxt;
    logic [15:0] tick, tick_nxt, lfsr, eval_base, bad_base;
    logic [7:0] th_gb, th_bg, snr_good, snr_bad, sample;
    logic eval, bad_nxt, unused_lfsr;

    channel_lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
        .clk(clk),
        .reset(reset),
        .advance(eval),
        .value(lfsr)
    );

    always_comb begin
        ctrl_nxt = ctrl;
        tick_nxt = tick;
        eval = 1'b0;
        if (ctrl == STOPPED) begin
            ctrl_nxt = bus.run ? RUNNING : STOPPED;
            tick_nxt = '0;
            eval = bus.step && !bus.run;
        end else if (!bus.run) begin
            ctrl_nxt = STOPPED;
            tick_nxt = '0;
        end else begin
            eval = tick == TICK_LAST;
            tick_nxt = eval ? '0 : tick + 16'd1;
        end
    end

    // Samples are 0..127, so a threshold of 0 always flips and >= 128 never does.
    assign sample = {1'b0, lfsr[6:0]};
    assign bad_nxt = bus.state_bad ^ (sample >= (bus.state_bad ? th_bg : th_gb));
    assign eval_base = bus.clr_stats ? '0 : bus.eval_count;
    assign bad_base = bus.clr_stats ? '0 : bus.bad_count;
    assign bus.snr_code = bus.state_bad ? snr_bad : snr_good;
    assign unused_lfsr = ^lfsr[15:7];

    always_ff @(posedge clk) begin
        if (reset) begin
            ctrl <= STOPPED;
            tick <= '0;
            th_gb <= DEF_TH_GB;
            th_bg <= DEF_TH_BG;
            snr_good <= DEF_SNR_GOOD;
            snr_bad <= DEF_SNR_BAD;
            bus.state_bad <= ST_GOOD;
            bus.rand_sample <= '0;
            bus.update <= 1'b0;
            bus.eval_count <= '0;
            bus.bad_count <= '0;
        end else begin
            ctrl <= ctrl_nxt;
            tick <= tick_nxt;
            bus.update <= eval;
            th_gb <= (bus.cfg_we && bus.cfg_addr == CFG_TH_GB) ? bus.cfg_wdata : th_gb;
            th_bg <= (bus.cfg_we && bus.cfg_addr == CFG_TH_BG) ? bus.cfg_wdata : th_bg;
            snr_good <= (bus.cfg_we && bus.cfg_addr == CFG_SNR_GOOD) ? bus.cfg_wdata : snr_good;
            snr_bad <= (bus.cfg_we && bus.cfg_addr == CFG_SNR_BAD) ? bus.cfg_wdata : snr_bad;
            bus.state_bad <= eval ? bad_nxt : bus.state_bad;
            bus.rand_sample <= eval ? lfsr[6:0] : bus.rand_sample;
            bus.eval_count <= eval ? sat_inc(eval_base) : eval_base;
            bus.bad_count <= (eval && bad_nxt == ST_BAD) ? sat_inc(bad_base) : bad_base;
        end
    end
endmodule

// File: tb/tb_channel_state_scheduler.sv
// tb_channel_state_scheduler: reference model + scoreboard, table-driven config/step vectors and directed timing sequences.
module tb_channel_state_scheduler;
    import channel_sched_pkg::*;
    localparam int TD = 4;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic checking = 1'b0;
    always #5 clk = ~clk;

    channel_state_scheduler_if bus();
    channel_state_scheduler #(.TICK_DIV(TD)) dut (.clk(clk), .reset(reset), .bus(bus));

    typedef struct {logic [6:0] sample; logic bad; logic [15:0] ec; logic [15:0] bc;} exp_t;
    typedef struct {logic we; logic [1:0] addr; logic [7:0] data; logic step; logic bad; logic [7:0] snr; logic [15:0] bc;} vec_t;
    exp_t sb[$];
    exp_t e;
    vec_t vt[12];
    int n_chk = 0;
    int n_fail = 0;

    // Reference model state, advanced on every posedge from the driven inputs.
    logic m_run, m_upd, m_bad, ev;
    int m_tick;
    logic [15:0] m_lfsr, m_ec, m_bc, base_e, base_b;
    logic [7:0] m_thgb, m_thbg, m_sg, m_sb;
    logic [6:0] s;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        if (reset) begin
            m_run = 0; m_tick = 0; m_upd = 0; m_bad = 0;
            m_lfsr = 16'hACE1; m_ec = 0; m_bc = 0;
            m_thgb = 8'd97; m_thbg = 8'd75; m_sg = 8'd21; m_sb = 8'd9;
            sb.delete();
        end else begin
            ev = 0;
            if (!m_run) begin
                if (bus.run) begin m_run = 1; m_tick = 0; end
                else ev = bus.step;
            end else if (!bus.run) begin
                m_run = 0; m_tick = 0;
            end else if (m_tick == TD - 1) begin
                ev = 1; m_tick = 0;
            end else m_tick++;
            m_upd = ev;
            base_e = bus.clr_stats ? 16'd0 : m_ec;
            base_b = bus.clr_stats ? 16'd0 : m_bc;
            if (ev) begin
                s = m_lfsr[6:0];
                if ({1'b0, s} >= (m_bad ? m_thbg : m_thgb)) m_bad = ~m_bad;
                m_ec = (base_e == 16'hFFFF) ? base_e : base_e + 1;
                m_bc = (m_bad && base_b != 16'hFFFF) ? base_b + 1 : base_b;
                m_lfsr = {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
                sb.push_back('{s, m_bad, m_ec, m_bc});
            end else begin
                m_ec = base_e; m_bc = base_b;
            end
            if (bus.cfg_we) begin
                if (bus.cfg_addr == 2'd0) m_thgb = bus.cfg_wdata;
                if (bus.cfg_addr == 2'd1) m_thbg = bus.cfg_wdata;
                if (bus.cfg_addr == 2'd2) m_sg = bus.cfg_wdata;
                if (bus.cfg_addr == 2'd3) m_sb = bus.cfg_wdata;
            end
        end
    end

    always @(negedge clk) begin
        if (checking) begin
            chk("update", bus.update, m_upd);
            chk("state_bad", bus.state_bad, m_bad);
            chk("snr_code", bus.snr_code, m_bad ? m_sb : m_sg);
            chk("eval_count", bus.eval_count, m_ec);
            chk("bad_count", bus.bad_count, m_bc);
            if (bus.update) begin
                if (sb.size() == 0) chk("sb_underflow", 1, 0);
                else begin
                    e = sb.pop_front();
                    chk("sb_rand_sample", bus.rand_sample, e.sample);
                    chk("sb_state", bus.state_bad, e.bad);
                    chk("sb_eval_count", bus.eval_count, e.ec);
                    chk("sb_bad_count", bus.bad_count, e.bc);
                end
            end
        end
    end

    task automatic cyc(logic we, logic [1:0] addr, logic [7:0] data, logic st, logic clr);
        bus.cfg_we = we; bus.cfg_addr = addr; bus.cfg_wdata = data; bus.step = st; bus.clr_stats = clr;
        @(negedge clk);
        bus.cfg_we = 0; bus.step = 0; bus.clr_stats = 0;
    endtask

    task automatic wait_upd(string name, int exp_n);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.update && n < 20);
        chk(name, n, exp_n);
    endtask

    task automatic do_reset();
        reset = 1;
        @(negedge clk);
        reset = 0;
    endtask

    initial begin
        bus.run = 0; bus.step = 0; bus.cfg_we = 0; bus.cfg_addr = 0; bus.cfg_wdata = 0; bus.clr_stats = 0;
        vt = '{
            '{1, CFG_TH_GB, 8'd0, 0, 0, 8'd21, 16'd0},
            '{0, 2'd0, 8'd0, 1, 1, 8'd9, 16'd1},
            '{1, CFG_TH_BG, 8'd200, 0, 1, 8'd9, 16'd1},
            '{0, 2'd0, 8'd0, 1, 1, 8'd9, 16'd2},
            '{0, 2'd0, 8'd0, 1, 1, 8'd9, 16'd3},
            '{0, 2'd0, 8'd0, 1, 1, 8'd9, 16'd4},
            '{1, CFG_SNR_BAD, 8'd5, 0, 1, 8'd5, 16'd4},
            '{1, CFG_TH_BG, 8'd0, 0, 1, 8'd5, 16'd4},
            '{0, 2'd0, 8'd0, 1, 0, 8'd21, 16'd4},
            '{1, CFG_TH_GB, 8'd200, 1, 1, 8'd5, 16'd5},
            '{0, 2'd0, 8'd0, 1, 0, 8'd21, 16'd5},
            '{0, 2'd0, 8'd0, 1, 0, 8'd21, 16'd5}
        };
        repeat (3) @(negedge clk);
        reset = 0;
        checking = 1;
        repeat (10) @(negedge clk);
        chk("idle_state", bus.state_bad, 0);
        chk("idle_snr", bus.snr_code, 21);
        chk("idle_count", bus.eval_count, 0);
        // Free-running cadence from the run rise.
        bus.run = 1;
        wait_upd("run_first", 5);
        repeat (3) wait_upd("run_period", 4);
        chk("run_eval_count", bus.eval_count, 4);
        bus.run = 0;
        @(negedge clk);
        do_reset();
        for (int i = 0; i < 12; i++) begin
            cyc(vt[i].we, vt[i].addr, vt[i].data, vt[i].step, 0);
            chk($sformatf("vec%0d_state", i), bus.state_bad, vt[i].bad);
            chk($sformatf("vec%0d_snr", i), bus.snr_code, vt[i].snr);
            chk($sformatf("vec%0d_bad_count", i), bus.bad_count, vt[i].bc);
        end
        // Step ignored while running; run drop at counter 2 restarts the count.
        do_reset();
        bus.run = 1;
        wait_upd("rerun_first", 5);
        cyc(0, 0, 0, 1, 0);
        wait_upd("step_ignored", 3);
        repeat (2) @(negedge clk);
        bus.run = 0;
        @(negedge clk);
        bus.run = 1;
        wait_upd("rerun_restart", 5);
        bus.run = 0;
        @(negedge clk);
        // clr_stats coinciding with an eval that lands in Bad.
        do_reset();
        cyc(1, CFG_TH_GB, 8'd0, 0, 0);
        cyc(1, CFG_TH_BG, 8'd200, 0, 0);
        cyc(0, 0, 0, 1, 0);
        cyc(0, 0, 0, 1, 0);
        cyc(0, 0, 0, 1, 0);
        chk("pre_clr_count", bus.eval_count, 3);
        cyc(0, 0, 0, 1, 1);
        chk("clr_eval_count", bus.eval_count, 1);
        chk("clr_bad_count", bus.bad_count, 1);
        // Saturation: a held step evaluates every cycle.
        bus.step = 1;
        repeat (65540) @(negedge clk);
        bus.step = 0;
        @(negedge clk);
        chk("sat_eval_count", bus.eval_count, 16'hFFFF);
        chk("sat_bad_count", bus.bad_count, 16'hFFFF);
        // Reset in the middle of a run.
        bus.run = 1;
        repeat (6) @(negedge clk);
        reset = 1;
        @(negedge clk);
        reset = 0;
        bus.run = 0;
        chk("midrst_update", bus.update, 0);
        chk("midrst_count", bus.eval_count, 0);
        chk("midrst_state", bus.state_bad, 0);
        repeat (6) @(negedge clk);
        chk("sb_drain", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/channel_state_scheduler.md
Name: channel_state_scheduler

Overview:
Sequencer and configuration front-end for the two-state (Good/Bad) burst-error channel model.
- Generates the state-evaluation strobe from the system clock, either free-running or single-step.
- Owns the uniform random source, the programmable transition thresholds and the per-state SNR codes.
- Drives the current channel state, SNR code and run statistics to the channel datapath and the debug bus.

Parameters:
TICK_DIV, 5000, system-clock cycles per evaluation in run mode (50 MHz -> 10 kHz); legal range 2..65535
LFSR_SEED, 16'hACE1, LFSR reset value; 0 is illegal and is replaced by 16'hACE1
DEF_TH_GB, 8'd97, reset value of the Good->Bad threshold
DEF_TH_BG, 8'd75, reset value of the Bad->Good threshold
DEF_SNR_GOOD, 8'd21, reset value of the Good-state SNR code
DEF_SNR_BAD, 8'd9, reset value of the Bad-state SNR code

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
run  in  1  level; 1 = free-running evaluations every TICK_DIV cycles
step  in  1  one-cycle pulse; requests a single evaluation when not running
cfg_we  in  1  config write strobe
cfg_addr  in  2  0 = th_gb, 1 = th_bg, 2 = snr_good, 3 = snr_bad
cfg_wdata  in  8  config write data
clr_stats  in  1  one-cycle pulse; clears eval_count and bad_count
update  out  1  one-cycle pulse; state/snr_code/rand_sample just updated
state_bad  out  1  0 = Good, 1 = Bad
snr_code  out  8  SNR code for the current state
rand_sample  out  7  random sample used by the last evaluation
eval_count  out  16  evaluations since reset or clear; saturates at 16'hFFFF
bad_count  out  16  evaluations that resulted in Bad; saturates at 16'hFFFF

Behaviour:
- Everything is clocked on posedge clk; reset is synchronous and active-high.
- Reset values:
  - state_bad = 0, snr_code = DEF_SNR_GOOD, rand_sample = 0, update = 0, counters = 0.
  - Thresholds and SNR registers take their DEF_* values; lfsr = LFSR_SEED; tick counter = 0; control FSM = STOPPED.
- Control FSM:
  - STOPPED: run = 1 -> RUNNING, with the tick counter cleared. step = 1 raises the eval strobe on that same cycle (FSM stays STOPPED).
  - RUNNING: the tick counter counts 0..TICK_DIV-1 and wraps. The eval strobe fires on the cycle the counter equals TICK_DIV-1. run = 0 -> STOPPED, counter cleared, no eval that cycle. step is ignored.
  - Simultaneous run rise and step: treated as run; no extra eval.
  - First free-running eval comes TICK_DIV cycles after the first cycle in RUNNING.
- Evaluation, on the eval-strobe cycle E:
  - sample = lfsr[6:0], zero-extended to 8 bits. The 16-bit Fibonacci LFSR (taps 16,14,13,11) advances once per eval only.
  - Good: sample >= th_gb -> Bad, else stay Good.
  - Bad: sample >= th_bg -> Good, else stay Bad.
  - Threshold 0 forces the transition every eval. Threshold >= 128 blocks it permanently.
- Outputs are registered, latency 1: at E+1, state_bad, snr_code, rand_sample and both counters hold the new values, and update = 1 for exactly that cycle.
- snr_code tracks the current snr_good/snr_bad register. An SNR write takes effect on snr_code the cycle after the write, even without an eval.
- Config writes are accepted in any state. A threshold write on cycle E is not used by that eval; it applies from the next eval on.
- clr_stats coinciding with an eval: the counters end at the values from that eval alone (1, and 1 or 0).
- Reset mid-run: reset wins over every other input; no update pulse is produced.

Decomposition:
- Package channel_sched_pkg holds:
  - state encoding (ST_GOOD = 1'b0, ST_BAD = 1'b1);
  - control FSM encoding (STOPPED, RUNNING);
  - cfg address constants (CFG_TH_GB = 0, CFG_TH_BG = 1, CFG_SNR_GOOD = 2, CFG_SNR_BAD = 3);
  - default thresholds, default SNR codes and the fallback seed 16'hACE1.
- One sub-module, channel_lfsr16, with inputs clk, reset, advance and output value[15:0], plus a SEED parameter.

Test Plan:
- Reset, then idle 10 cycles -> state_bad = 0, snr_code = 21, update never asserted, counters = 0.
- TICK_DIV = 4, run = 1 held 17 cycles -> update pulses at cycles 5, 9, 13, 17 after run rises; eval_count = 4; rand_sample matches the reference LFSR sequence from seed 16'hACE1.
- Write th_gb = 0, then step -> next cycle update = 1, state_bad = 1, snr_code = 9, bad_count = 1. Then write th_bg = 8'd200 and step 3 times -> state stays Bad, bad_count = 4.
- In Bad, write snr_bad = 8'd5 with no eval -> snr_code = 5 one cycle later. Write th_bg = 0 and step -> state_bad = 0, snr_code = 21.
- RUNNING with TICK_DIV = 4: assert step mid-count -> no extra update. Drop run at counter = 2, then raise it again -> next update comes 4 cycles after re-entering RUNNING.
- clr_stats on the same cycle as an eval resulting in Bad -> eval_count = 1, bad_count = 1. Force eval_count to 16'hFFFF via a long run -> it holds at 16'hFFFF.
